// File: rtl/clk_div_sched.sv
// clk_div_sched: run/stop and ratio-change sequencer for an integer
// clock divider; changes land only on period boundaries.
//
// Ports:
//   clk_in      sole clock (posedge)
//   rst         synchronous active-high reset
//   run         level: 1 = run, 0 = stop at end of current period
//   cfg_req     level ratio-change request, held until cfg_ack
//   cfg_div     requested ratio, stable while cfg_req
//   cfg_ack     one-cycle pulse: request applied or rejected
//   cfg_err     with cfg_ack: 1 = rejected (ratio < 2)
//   clk_out     registered divided clock
//   tick        one-cycle pulse in the last cycle of each period
//   busy        1 when not IDLE
//   div_cur     ratio currently in effect
//   period_cnt  (CLK_DIV_SCHED_PERIOD_CNT_EN only) 16-bit tick counter
//
// Optional macro: CLK_DIV_SCHED_PERIOD_CNT_EN
module clk_div_sched #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic [DIV_W-1:0] div_cur
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    state_t           state;
    state_t           nxt_state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] nxt_cnt;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] nxt_div;
    logic             pend;
    logic             nxt_pend;
    logic             acc;
    logic             bad;
    logic             nxt_ack;
    logic             nxt_err;

    // The registered tick marks the boundary cycle, so it doubles as
    // the "period ends now" condition for all sequencing below.
    always_comb begin
        acc       = cfg_req && !pend && !cfg_ack;
        bad       = cfg_div < TWO;
        nxt_state = state;
        nxt_div   = div_cur;
        nxt_pend  = pend;
        nxt_ack   = 1'b0;
        nxt_err   = 1'b0;

        unique case (state)
            IDLE: if (run) nxt_state = RUN;
            RUN:  if (!run) nxt_state = STOP;
            STOP: begin
                if (run)       nxt_state = RUN;
                else if (tick) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase

        if (nxt_state == IDLE || state == IDLE || tick)
            nxt_cnt = '0;
        else
            nxt_cnt = cnt + ONE;

        if (tick && pend) begin
            nxt_div  = div_pend;
            nxt_pend = 1'b0;
            nxt_ack  = 1'b1;
        end

        // acc implies !pend, so this never collides with the apply above.
        if (acc) begin
            nxt_ack = 1'b1;
            if (bad) begin
                nxt_err = 1'b1;
            end else if (state == IDLE || tick) begin
                nxt_div = cfg_div;
            end else begin
                nxt_ack  = 1'b0;
                nxt_pend = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= 1'b0;
            div_pend <= DEF;
            div_cur  <= DEF;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            pend    <= nxt_pend;
            div_cur <= nxt_div;
            cfg_ack <= nxt_ack;
            cfg_err <= nxt_err;
            busy    <= nxt_state != IDLE;
            if (acc && !bad)
                div_pend <= cfg_div;
            // Outputs track the cnt/ratio being loaded this edge.
            clk_out <= (nxt_state != IDLE) &&
                       (nxt_cnt < (nxt_div >> 1));
            tick    <= (nxt_state != IDLE) &&
                       (nxt_cnt == nxt_div - ONE);
        end
    end

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    always_ff @(posedge clk_in) begin
        if (rst)
            period_cnt <= '0;
        else if (state == IDLE && nxt_state == RUN)
            period_cnt <= '0;
        else if (tick)
            period_cnt <= period_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: directed vector table plus hand sequences for
// clk_div_sched with DIV_W=8, DEF_DIV=2.
module tb_clk_div_sched;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       run;
    logic       cfg_req;
    logic [7:0] cfg_div;
    logic       cfg_ack;
    logic       cfg_err;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic [7:0] div_cur;
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    clk_div_sched #(.DIV_W(8), .DEF_DIV(2)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .run     (run),
        .cfg_req (cfg_req),
        .cfg_div (cfg_div),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy),
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
        .period_cnt (period_cnt),
`endif
        .div_cur (div_cur)
    );

    always #5 clk_in = ~clk_in;

    // Inputs are applied before an edge; expectations are the
    // outputs right after that edge.
    typedef struct {
        logic       rst;
        logic       run;
        logic       req;
        logic [7:0] div;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic r, input logic rn, input logic rq,
        input logic [7:0] d,
        input logic c, input logic t, input logic a,
        input logic e, input logic b, input logic [7:0] dc
    );
        vec_t x;
        x.rst = r;
        x.run = rn;
        x.req = rq;
        x.div = d;
        x.exp = {c, t, a, e, b, dc};
        return x;
    endfunction

    function automatic logic [12:0] got();
        return {clk_out, tick, cfg_ack, cfg_err, busy, div_cur};
    endfunction

    task automatic step(
        input logic r, input logic rn, input logic rq,
        input logic [7:0] d
    );
        rst     = r;
        run     = rn;
        cfg_req = rq;
        cfg_div = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = got();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got clk/tick/ack/err/busy=%b div=%0d, want %b div=%0d",
                     name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        cfg_req = 1'b0;
        cfg_div = 8'd0;

        // reset state
        vecs.push_back(v(1,0,0,0, 0,0,0,0,0,2));
        // N=2 start: 1,0,1,0 with tick on low
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,2));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,2));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,2));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,2));
        // run dropped in tick cycle: one more full period then IDLE
        vecs.push_back(v(0,0,0,0, 1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0, 0,1,0,0,1,2));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,0,2));
        // IDLE config N=5
        vecs.push_back(v(0,0,1,5, 0,0,1,0,0,5));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,0,5));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,5));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,5));
        vecs.push_back(v(0,1,0,0, 0,0,0,0,1,5));
        vecs.push_back(v(0,1,0,0, 0,0,0,0,1,5));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,5));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,5));
        // N=4 running, request 6 at cnt=1
        vecs.push_back(v(1,0,0,0, 0,0,0,0,0,2));
        vecs.push_back(v(0,0,1,4, 0,0,1,0,0,4));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,4));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,4));
        vecs.push_back(v(0,1,1,6, 0,0,0,0,1,4));
        vecs.push_back(v(0,1,1,6, 0,1,0,0,1,4));
        vecs.push_back(v(0,1,1,6, 1,0,1,0,1,6));
        // req still high in ack cycle: must not be re-accepted
        vecs.push_back(v(0,1,1,6, 1,0,0,0,1,6));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,6));
        vecs.push_back(v(0,1,0,0, 0,0,0,0,1,6));
        vecs.push_back(v(0,1,0,0, 0,0,0,0,1,6));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,6));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,6));
        // N=3: stop at cnt0, period completes, IDLE
        vecs.push_back(v(1,0,0,0, 0,0,0,0,0,2));
        vecs.push_back(v(0,0,1,3, 0,0,1,0,0,3));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,3));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,1,3));
        vecs.push_back(v(0,0,0,0, 0,1,0,0,1,3));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,0,3));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,0,3));
        // stop then resume at cnt1: no gap
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,3));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,1,3));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,3));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,3));
        vecs.push_back(v(0,1,0,0, 0,0,0,0,1,3));
        // illegal ratios 1 and 0
        vecs.push_back(v(0,1,1,1, 0,1,1,1,1,3));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,3));
        vecs.push_back(v(0,1,1,0, 0,0,1,1,1,3));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,3));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,3));
        // request accepted in tick cycle: next period uses it
        vecs.push_back(v(0,1,0,0, 0,0,0,0,1,3));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,3));
        vecs.push_back(v(0,1,1,4, 1,0,1,0,1,4));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,4));
        vecs.push_back(v(0,1,0,0, 0,0,0,0,1,4));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,4));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,4));
        // pending request then reset: dropped, no ack
        vecs.push_back(v(0,1,1,7, 1,0,0,0,1,4));
        vecs.push_back(v(1,1,1,7, 0,0,0,0,0,2));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,0,2));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,2));
        vecs.push_back(v(0,1,0,0, 0,1,0,0,1,2));
        vecs.push_back(v(0,1,0,0, 1,0,0,0,1,2));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].run, vecs[i].req, vecs[i].div);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Pending request applied at the final tick into IDLE.
        step(0, 0, 1, 8'd6);
        check("stop_pend_tick", {5'b01001, 8'd2});
        step(0, 0, 1, 8'd6);
        check("stop_pend_idle", {5'b00100, 8'd6});
        step(0, 0, 0, 8'd0);
        check("stop_pend_after", {5'b00000, 8'd6});

        // Restart with the new ratio: 3 high, 3 low.
        step(0, 1, 0, 8'd0);
        check("restart_c0", {5'b10001, 8'd6});
        step(0, 1, 0, 8'd0);
        step(0, 1, 0, 8'd0);
        check("restart_c2", {5'b10001, 8'd6});
        step(0, 1, 0, 8'd0);
        check("restart_c3", {5'b00001, 8'd6});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
